// File: rtl/alu_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : alu_sequencer
// Description : Multi-cycle controller that runs one accumulator-style ALU
//               operation per request. It reads R0 (accumulator) and RX from
//               a synchronous register file, drives an external combinational
//               ALU, writes the result back to R0 and keeps registered Z/C/N
//               flags.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters  : DW       data width of register file / ALU operands / result
//               AW       register-file address width
//               ACC_ADDR register-file index used as accumulator R0
// Ports       : clk, rst_n                   clock, async active-low reset
//               req_valid/req_ready          request handshake
//               req_op/req_rx/req_cond       request fields (held until accept)
//               rf_raddr/rf_rdata            register-file read port (1-cycle)
//               rf_we/rf_waddr/rf_wdata      register-file write port
//               alu_r0/alu_rx/alu_op         registered ALU operands / op
//               alu_res/alu_carry            ALU result and bit DW
//               flags                        registered {Z, C, N}
//               done                         one-cycle completion pulse
// Config      : ALU_SEQ_COND_EN - when defined, req_cond is evaluated against
//               flags at acceptance; a false condition skips the operation.
// ============================================================================
module alu_sequencer #(
  parameter int DW       = 8,
  parameter int AW       = 3,
  parameter int ACC_ADDR = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [2:0]    req_op,
  input  logic [AW-1:0] req_rx,
  input  logic [1:0]    req_cond,
  output logic [AW-1:0] rf_raddr,
  input  logic [DW-1:0] rf_rdata,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic [DW-1:0] alu_r0,
  output logic [DW-1:0] alu_rx,
  output logic [2:0]    alu_op,
  input  logic [DW-1:0] alu_res,
  input  logic          alu_carry,
  output logic [2:0]    flags,
  output logic          done
);

  localparam logic [AW-1:0] C_ACC = AW'(ACC_ADDR);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD0  = 3'd1,
    S_RDX  = 3'd2,
    S_RDW  = 3'd3,
    S_WB   = 3'd4,
    S_SKIP = 3'd5
  } state_t;

  state_t        state, state_nxt;
  logic [2:0]    op_q;
  logic [AW-1:0] rx_q;
  logic          accept;
  logic          exec_ok;
  logic          carry_sel;

  assign accept = req_valid && (state == S_IDLE);

`ifdef ALU_SEQ_COND_EN
  // Condition is judged against the flags as they stand at the accepting edge.
  always_comb begin
    exec_ok = 1'b1;
    case (req_cond)
      2'b00:   exec_ok = 1'b1;
      2'b01:   exec_ok = flags[2];
      2'b10:   exec_ok = flags[1];
      default: exec_ok = flags[0];
    endcase
  end
`else
  logic unused_cond;
  assign exec_ok     = 1'b1;
  assign unused_cond = ^req_cond;
`endif

  // Carry is meaningful only for add, sub (borrow) and shift-left.
  assign carry_sel = (alu_op == 3'b000 || alu_op == 3'b001 || alu_op == 3'b010)
                     ? alu_carry : 1'b0;

  // State register and datapath captures
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      op_q   <= 3'b000;
      rx_q   <= '0;
      alu_r0 <= '0;
      alu_rx <= '0;
      alu_op <= 3'b000;
      flags  <= 3'b000;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q <= req_op;
        rx_q <= req_rx;
      end
      // Read data lags the address by one cycle: R0 arrives during RDX,
      // RX arrives during RDW.
      if (state == S_RDX) begin
        alu_r0 <= rf_rdata;
      end
      if (state == S_RDW) begin
        alu_rx <= rf_rdata;
        alu_op <= op_q;
      end
      if (state == S_WB) begin
        flags <= {(alu_res == '0), carry_sel, alu_res[DW-1]};
      end
    end
  end

  // Next-state and output decode
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rf_raddr  = C_ACC;
    rf_we     = 1'b0;
    rf_waddr  = C_ACC;
    rf_wdata  = alu_res;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_nxt = exec_ok ? S_RD0 : S_SKIP;
        end
      end
      S_RD0: begin
        state_nxt = S_RDX;
      end
      S_RDX: begin
        rf_raddr  = rx_q;
        state_nxt = S_RDW;
      end
      S_RDW: begin
        state_nxt = S_WB;
      end
      S_WB: begin
        rf_we     = 1'b1;
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      S_SKIP: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_alu_sequencer
// Description : Directed self-checking bench for alu_sequencer. Provides a
//               synchronous 8x8 register file and a combinational ALU model
//               around the controller; expected values are hand-computed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_sequencer;

  localparam int DW = 8;
  localparam int AW = 3;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [2:0]    req_op;
  logic [AW-1:0] req_rx;
  logic [1:0]    req_cond;
  logic [AW-1:0] rf_raddr;
  logic [DW-1:0] rf_rdata;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [DW-1:0] alu_r0;
  logic [DW-1:0] alu_rx;
  logic [2:0]    alu_op;
  logic [DW-1:0] alu_res;
  logic          alu_carry;
  logic [2:0]    flags;
  logic          done;

  int n_tests = 0;
  int n_fail  = 0;

  alu_sequencer #(.DW(DW), .AW(AW), .ACC_ADDR(0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_rx    (req_rx),
    .req_cond  (req_cond),
    .rf_raddr  (rf_raddr),
    .rf_rdata  (rf_rdata),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .alu_r0    (alu_r0),
    .alu_rx    (alu_rx),
    .alu_op    (alu_op),
    .alu_res   (alu_res),
    .alu_carry (alu_carry),
    .flags     (flags),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: bench preload port has priority, one-cycle read.
  logic [DW-1:0] mem [0:7];
  logic          tb_we;
  logic [AW-1:0] tb_waddr;
  logic [DW-1:0] tb_wdata;

  always @(posedge clk) begin
    if (tb_we) mem[tb_waddr] <= tb_wdata;
    else if (rf_we) mem[rf_waddr] <= rf_wdata;
    rf_rdata <= mem[rf_raddr];
  end

  // ALU model
  logic [DW:0] alu_full;
  always_comb begin
    alu_full = '0;
    case (alu_op)
      3'b000:  alu_full = {1'b0, alu_r0} + {1'b0, alu_rx};
      3'b001:  alu_full = {1'b0, alu_r0} - {1'b0, alu_rx};
      3'b010:  alu_full = {alu_r0, 1'b0};
      3'b011:  alu_full = {2'b00, alu_r0[DW-1:1]};
      3'b100:  alu_full = {1'b0, ~alu_r0};
      3'b101:  alu_full = {1'b0, alu_r0 & alu_rx};
      3'b110:  alu_full = {1'b0, alu_r0 | alu_rx};
      default: alu_full = {1'b0, alu_r0 ^ alu_rx};
    endcase
  end
  assign alu_res   = alu_full[DW-1:0];
  assign alu_carry = alu_full[DW];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic write_reg(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    tb_we    = 1'b1;
    tb_waddr = a;
    tb_wdata = d;
    @(negedge clk);
    tb_we    = 1'b0;
  endtask

  // Results of the last issued operation
  int            done_cyc;
  int            done_cnt;
  int            we_cnt;
  logic [AW-1:0] raddr1, raddr2;
  logic [DW-1:0] wdata_seen;
  logic [AW-1:0] waddr_seen;

  // Issue one request and observe 8 cycles after the accepting edge.
  // With hold set, req_valid stays high until DONE is seen.
  task automatic issue(input logic [2:0] op, input logic [AW-1:0] rx,
                       input logic [1:0] cond, input bit hold);
    @(negedge clk);
    req_op    = op;
    req_rx    = rx;
    req_cond  = cond;
    req_valid = 1'b1;
    @(posedge clk);
    if (!hold) #1 req_valid = 1'b0;
    done_cyc = -1;
    done_cnt = 0;
    we_cnt   = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) raddr1 = rf_raddr;
      if (c == 2) raddr2 = rf_raddr;
      if (rf_we) we_cnt++;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc   = c;
          wdata_seen = rf_wdata;
          waddr_seen = rf_waddr;
        end
        req_valid = 1'b0;
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_op    = 3'b000;
    req_rx    = '0;
    req_cond  = 2'b00;
    tb_we     = 1'b0;
    tb_waddr  = '0;
    tb_wdata  = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    check("rst_flags", {29'b0, flags}, 32'd0);
    check("rst_we", {31'b0, rf_we}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_raddr", {29'b0, rf_raddr}, 32'd0);
    check("rst_alu_r0", {24'b0, alu_r0}, 32'd0);
    rst_n = 1'b1;

    // 7F + 01 -> 80, flags N
    write_reg(3'd0, 8'h7F);
    write_reg(3'd3, 8'h01);
    issue(3'b000, 3'd3, 2'b00, 1'b0);
    check("add_done_cyc", done_cyc, 32'd4);
    check("add_raddr1", {29'b0, raddr1}, 32'd0);
    check("add_raddr2", {29'b0, raddr2}, 32'd3);
    check("add_wdata", {24'b0, wdata_seen}, 32'h80);
    check("add_waddr", {29'b0, waddr_seen}, 32'd0);
    check("add_r0", {24'b0, mem[0]}, 32'h80);
    check("add_flags", {29'b0, flags}, 32'b001);

    // FF + 01 -> 00 with carry, then AND -> 00
    write_reg(3'd0, 8'hFF);
    write_reg(3'd1, 8'h01);
    issue(3'b000, 3'd1, 2'b00, 1'b0);
    check("addc_r0", {24'b0, mem[0]}, 32'h00);
    check("addc_flags", {29'b0, flags}, 32'b110);
    issue(3'b101, 3'd1, 2'b00, 1'b0);
    check("and_r0", {24'b0, mem[0]}, 32'h00);
    check("and_flags", {29'b0, flags}, 32'b100);

    // Back-to-back: 03 - 05 = FE (borrow), then shr -> 7F
    write_reg(3'd0, 8'h03);
    write_reg(3'd4, 8'h05);
    write_reg(3'd5, 8'h99);
    @(negedge clk);
    req_op    = 3'b001;
    req_rx    = 3'd4;
    req_cond  = 2'b00;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    begin
      int first_done;
      int second_done;
      first_done  = -1;
      second_done = -1;
      for (int c = 1; c <= 12; c++) begin
        @(negedge clk);
        if (c == 5) check("b2b_ready5", {31'b0, req_ready}, 32'd1);
        if (c == 6) begin
          check("b2b_raddr6", {29'b0, rf_raddr}, 32'd0);
          req_valid = 1'b0;
        end
        if (c == 7) check("b2b_raddr7", {29'b0, rf_raddr}, 32'd5);
        if (done) begin
          if (first_done < 0) begin
            first_done = c;
            check("sub_wdata", {24'b0, rf_wdata}, 32'hFE);
            req_op    = 3'b011;
            req_rx    = 3'd5;
            req_valid = 1'b1;
          end else if (second_done < 0) begin
            second_done = c;
          end
        end
        if (c == 5) check("sub_flags", {29'b0, flags}, 32'b011);
      end
      check("b2b_first_done", first_done, 32'd4);
      check("b2b_second_done", second_done, 32'd9);
    end
    check("shr_r0", {24'b0, mem[0]}, 32'h7F);
    check("shr_flags", {29'b0, flags}, 32'b000);

    // RX == accumulator, valid held while busy -> exactly one operation
    write_reg(3'd0, 8'h55);
    issue(3'b111, 3'd0, 2'b00, 1'b1);
    check("xor_done_cyc", done_cyc, 32'd4);
    check("xor_done_cnt", done_cnt, 32'd1);
    check("xor_we_cnt", we_cnt, 32'd1);
    check("xor_r0", {24'b0, mem[0]}, 32'h00);
    check("xor_flags", {29'b0, flags}, 32'b100);

    // Reset in the middle of write-back
    write_reg(3'd0, 8'h10);
    write_reg(3'd2, 8'h20);
    @(negedge clk);
    req_op    = 3'b000;
    req_rx    = 3'd2;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_done_before", {31'b0, done}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_we", {31'b0, rf_we}, 32'd0);
    check("mid_done", {31'b0, done}, 32'd0);
    check("mid_flags", {29'b0, flags}, 32'd0);
    check("mid_ready", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    check("mid_r0_kept", {24'b0, mem[0]}, 32'h10);
    rst_n = 1'b1;

    // Conditional execution: Z=0, COND=01 (if Z)
    issue(3'b000, 3'd2, 2'b01, 1'b0);
`ifdef ALU_SEQ_COND_EN
    check("cond_skip_done_cyc", done_cyc, 32'd1);
    check("cond_skip_we", we_cnt, 32'd0);
    check("cond_skip_r0", {24'b0, mem[0]}, 32'h10);
    check("cond_skip_flags", {29'b0, flags}, 32'b000);
    check("cond_skip_alu_r0", {24'b0, alu_r0}, 32'h00);
    issue(3'b000, 3'd2, 2'b00, 1'b0);
    check("cond_always_done_cyc", done_cyc, 32'd4);
    check("cond_always_r0", {24'b0, mem[0]}, 32'h30);
`else
    check("nocond_done_cyc", done_cyc, 32'd4);
    check("nocond_we", we_cnt, 32'd1);
    check("nocond_r0", {24'b0, mem[0]}, 32'h30);
    issue(3'b000, 3'd2, 2'b00, 1'b0);
    check("nocond2_r0", {24'b0, mem[0]}, 32'h50);
`endif
    check("cond_final_flags", {29'b0, flags}, 32'b000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
